// File: rtl/db_pkg.sv
// db_pkg -- shared constants and helpers for the db_multi debouncer.
//
// Contents:
//   DB_DEFAULT_DIV     default clk cycles per sample tick
//   DB_DEFAULT_STABLE  default number of differing ticks needed to accept a level
//   DB_DEFAULT_HOLD    default ticks of continuous high before a long-press pulse
//   db_cnt_w(n)        width of a counter that must be able to hold the value n
package db_pkg;

  localparam int unsigned DB_DEFAULT_DIV    = 100000;
  localparam int unsigned DB_DEFAULT_STABLE = 4;
  localparam int unsigned DB_DEFAULT_HOLD   = 100;

  // One bit more than $clog2 so the value n itself always fits
  // (and n=1 still yields a 1-bit counter).
  function automatic int unsigned db_cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/db_tick_gen.sv
// db_tick_gen -- free-running prescaler producing the shared sample tick.
//
// Parameters:
//   DIV    clk cycles per tick (>= 2)
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   tick   out  high for exactly one cycle while the counter sits at DIV-1
//
// The counter starts at 0 out of reset, so the first tick is seen DIV cycles
// after rst_n deasserts.
module db_tick_gen
  import db_pkg::*;
#(
  parameter int unsigned DIV = DB_DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  logic [PW-1:0] div_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign tick = (div_cnt_reg == DIV_LAST);

endmodule

// File: rtl/db_multi.sv
// db_multi -- multi-channel push-button / switch debouncer.
//
// Each raw input is passed through a two-flop synchroniser, sampled on a
// shared prescaled tick, and accepted as the new debounced level only after
// STABLE_TICKS consecutive tick samples differ from the current level. Any
// agreeing sample restarts the qualification.
//
// Parameters:
//   N_CH          number of independent channels (>= 1)
//   DIV           clk cycles per sample tick (>= 2)
//   STABLE_TICKS  consecutive differing ticks needed to accept a level (>= 1)
//   HOLD_TICKS    ticks of continuous high before long_press (>= 1)
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   raw_in      in   [N_CH] raw asynchronous inputs
//   db          out  [N_CH] debounced levels
//   rise        out  [N_CH] one-cycle pulse when db goes 0->1
//   fall        out  [N_CH] one-cycle pulse when db goes 1->0
//   long_press  out  [N_CH] one-cycle pulse after HOLD_TICKS ticks of db high
//
// Build option: define DB_LONG_PRESS_EN to build the per-channel hold
// counters. Without it long_press is constant 0.
module db_multi
  import db_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DIV          = DB_DEFAULT_DIV,
  parameter int unsigned STABLE_TICKS = DB_DEFAULT_STABLE,
  parameter int unsigned HOLD_TICKS   = DB_DEFAULT_HOLD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press
);

  localparam int unsigned CW = db_cnt_w(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic tick;

  db_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < int'(N_CH); gi++) begin : g_ch
      logic          sync1_reg;
      logic          sync2_reg;
      logic          db_reg;
      logic          rise_reg;
      logic          fall_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= raw_in[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // cnt_reg counts differing samples already seen; the sample that would
      // make it reach STABLE_TICKS commits the new level instead.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          db_reg   <= 1'b0;
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          cnt_reg  <= '0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          if (tick) begin
            if (sync2_reg != db_reg) begin
              if (cnt_reg == CNT_LAST) begin
                db_reg   <= sync2_reg;
                cnt_reg  <= '0;
                rise_reg <= sync2_reg;
                fall_reg <= ~sync2_reg;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end else begin
              cnt_reg <= '0;
            end
          end
        end
      end

      assign db[gi]   = db_reg;
      assign rise[gi] = rise_reg;
      assign fall[gi] = fall_reg;

`ifdef DB_LONG_PRESS_EN
      localparam int unsigned HW = db_cnt_w(HOLD_TICKS);
      localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
      localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_TICKS - 1);

      logic [HW-1:0] hold_reg;
      logic          lp_reg;

      // Saturating at HOLD_MAX is what stops repeat pulses while held; the
      // counter only rearms once db drops.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_reg <= '0;
          lp_reg   <= 1'b0;
        end else begin
          lp_reg <= 1'b0;
          if (!db_reg) begin
            hold_reg <= '0;
          end else if (tick && (hold_reg != HOLD_MAX)) begin
            hold_reg <= hold_reg + 1'b1;
            if (hold_reg == HOLD_PRE) begin
              lp_reg <= 1'b1;
            end
          end
        end
      end

      assign long_press[gi] = lp_reg;
`else
      assign long_press[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_db_multi.sv
// tb_db_multi -- self-checking bench for db_multi.
//
// Two instances share the same inputs: dut_a with STABLE_TICKS=3 and dut_b
// with STABLE_TICKS=1 (both N_CH=4, DIV=4, HOLD_TICKS=5). A behavioural model
// tracks, per channel, how many consecutive tick samples disagreed with the
// accepted level, and every clock all outputs of both instances are compared.
module tb_db_multi;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int HOLD  = 5;
  localparam int ST_A  = 3;
  localparam int ST_B  = 1;
`ifdef DB_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] db_a, rise_a, fall_a, lp_a;
  logic [N-1:0] db_b, rise_b, fall_b, lp_b;

  db_multi #(.N_CH(N), .DIV(DIV), .STABLE_TICKS(ST_A), .HOLD_TICKS(HOLD)) dut_a (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .db(db_a), .rise(rise_a), .fall(fall_a), .long_press(lp_a)
  );

  db_multi #(.N_CH(N), .DIV(DIV), .STABLE_TICKS(ST_B), .HOLD_TICKS(HOLD)) dut_b (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .db(db_b), .rise(rise_b), .fall(fall_b), .long_press(lp_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  logic [N-1:0] m_p1, m_p2;          // input as seen 1 and 2 clocks ago
  logic [N-1:0] m_db[2], m_rise[2], m_fall[2], m_lp[2];
  int           m_run[2][N];         // consecutive disagreeing samples
  int           m_hold[2][N];        // ticks seen while accepted level is high
  int           m_edges;             // clock edges since reset release

  function automatic int st_of(input int m);
    return (m == 0) ? ST_A : ST_B;
  endfunction

  task automatic model_reset();
    m_p1 = '0;
    m_p2 = '0;
    m_edges = 0;
    for (int m = 0; m < 2; m++) begin
      m_db[m] = '0; m_rise[m] = '0; m_fall[m] = '0; m_lp[m] = '0;
      for (int c = 0; c < N; c++) begin
        m_run[m][c] = 0;
        m_hold[m][c] = 0;
      end
    end
  endtask

  // Advance the model across one rising edge, using values from before it.
  task automatic model_edge();
    bit tick;
    tick = ((m_edges % DIV) == DIV - 1);
    for (int m = 0; m < 2; m++) begin
      logic [N-1:0] old_db;
      old_db = m_db[m];
      m_rise[m] = '0; m_fall[m] = '0; m_lp[m] = '0;
      for (int c = 0; c < N; c++) begin
        if (tick) begin
          if (m_p2[c] != old_db[c]) begin
            if (m_run[m][c] + 1 >= st_of(m)) begin
              m_db[m][c] = m_p2[c];
              m_run[m][c] = 0;
              if (m_p2[c]) m_rise[m][c] = 1'b1;
              else         m_fall[m][c] = 1'b1;
            end else begin
              m_run[m][c]++;
            end
          end else begin
            m_run[m][c] = 0;
          end
        end
        if (!old_db[c]) begin
          m_hold[m][c] = 0;
        end else if (tick && m_hold[m][c] < HOLD) begin
          m_hold[m][c]++;
          if (m_hold[m][c] == HOLD && LP_EN) m_lp[m][c] = 1'b1;
        end
      end
    end
    m_p2 = m_p1;
    m_p1 = raw_in;
    m_edges++;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("db_a",   int'(db_a),   int'(m_db[0]));
    check("rise_a", int'(rise_a), int'(m_rise[0]));
    check("fall_a", int'(fall_a), int'(m_fall[0]));
    check("lp_a",   int'(lp_a),   int'(m_lp[0]));
    check("db_b",   int'(db_b),   int'(m_db[1]));
    check("rise_b", int'(rise_b), int'(m_rise[1]));
    check("fall_b", int'(fall_b), int'(m_fall[1]));
    check("lp_b",   int'(lp_b),   int'(m_lp[1]));
  endtask

  // Called #1 after an edge: inputs are already set for the coming edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic reset_pulse(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (cycles) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int lat;
  int cnt_r, cnt_f, cnt_lp;
  bit seen;

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    reset_pulse(2);

    // 1. clean press on channel 0
    raw_in[0] = 1'b1;
    lat = 0;
    while (db_a[0] == 1'b0 && lat < 40) begin
      step();
      lat++;
    end
    check("s1_latency_in_11_14", int'(lat >= 11 && lat <= 14), 1);
    check("s1_others_low", int'(db_a[3:1]), 0);
    repeat (10) step();
    raw_in[0] = 1'b0;
    repeat (20) step();

    // 2. bounce on channel 1: high runs too short to qualify
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) raw_in[1] = ~raw_in[1];
      step();
      if (db_a[1] || rise_a[1] || fall_a[1]) seen = 1'b1;
    end
    raw_in[1] = 1'b0;
    repeat (20) begin
      step();
      if (db_a[1] || rise_a[1] || fall_a[1]) seen = 1'b1;
    end
    check("s2_bounce_ignored", int'(seen), 0);

    // 3. simultaneous transitions
    raw_in = 4'b1010;
    lat = 0;
    while (db_a == 4'b0000 && lat < 40) begin
      step();
      lat++;
    end
    check("s3_db_together", int'(db_a), 'ha);
    check("s3_rise_together", int'(rise_a), 'ha);
    repeat (10) step();
    raw_in = 4'b0000;
    lat = 0;
    while (db_a != 4'b0000 && lat < 40) begin
      step();
      lat++;
    end
    check("s3_fall_together", int'(fall_a), 'ha);
    repeat (10) step();

    // 4. reset mid-qualification
    raw_in[2] = 1'b1;
    repeat (8) step();
    reset_pulse(1);
    lat = 0;
    while (db_a[2] == 1'b0 && lat < 40) begin
      step();
      lat++;
    end
    check("s4_requalify_11_14", int'(lat >= 11 && lat <= 14), 1);
    raw_in[2] = 1'b0;
    repeat (20) step();

    // 5. long press on channel 3, released and pressed again
    cnt_lp = 0;
    for (int p = 0; p < 2; p++) begin
      raw_in[3] = 1'b1;
      repeat (60) begin
        step();
        if (lp_a[3]) cnt_lp++;
      end
      raw_in[3] = 1'b0;
      repeat (20) begin
        step();
        if (lp_a[3]) cnt_lp++;
      end
    end
    check("s5_long_press_count", cnt_lp, LP_EN ? 2 : 0);

    // 6. STABLE_TICKS=1: input high across exactly one tick
    cnt_r = 0;
    cnt_f = 0;
    raw_in[0] = 1'b1;
    repeat (DIV) begin
      step();
      cnt_r += int'(rise_b[0]);
      cnt_f += int'(fall_b[0]);
    end
    raw_in[0] = 1'b0;
    repeat (20) begin
      step();
      cnt_r += int'(rise_b[0]);
      cnt_f += int'(fall_b[0]);
    end
    check("s6_rise_once", cnt_r, 1);
    check("s6_fall_once", cnt_f, 1);
    check("s6_slow_ch_untouched", int'(db_a[0]), 0);

    // randomized phases, occasional resets
    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_pulse($urandom_range(1, 3));
      end
      raw_in = N'($urandom);
      repeat ($urandom_range(1, 40)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
